// File: rtl/sample_mux_packer_if.sv
// Sample-source and byte-stream bundle for the sample mux/packer.
// The master side drives source samples and out_ready; the packer is the slave.
interface sample_mux_packer_if #(
    parameter int WIDTH = 12,
    parameter int NSRC  = 2
) ();
    logic [NSRC-1:0]       in_valid;
    logic [NSRC*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic                  out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sample_mux_packer.sv
// Sample source select plus WIDTH-to-8 LSB-first packer with backpressure,
// drop accounting and a zero-padded flush when the stream is stopped.
module sample_mux_packer #(
    parameter int WIDTH  = 12,
    parameter int NSRC   = 2,
    parameter int MODE_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                enable,
    input  logic [MODE_W-1:0]   mode,
    input  logic                clr,
    sample_mux_packer_if.slave  bus,
    output logic                busy,
    output logic                overflow,
    output logic [CNT_W-1:0]    drop_count
);
    localparam int ACC_W  = 2*WIDTH + 7;
    localparam int FILL_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [MODE_W-1:0]  sel;
    logic [ACC_W-1:0]   acc;
    logic [FILL_W-1:0]  fill;
    logic               out_valid_q;
    logic [7:0]         out_data_q;

    logic               mode_ok;
    logic               cand_valid;
    logic [WIDTH-1:0]   cand_data;
    logic               loadable;
    logic               emit_full;
    logic               emit_part;
    logic               emit;
    logic [FILL_W-1:0]  fill_base;
    logic [ACC_W-1:0]   acc_base;
    logic               fits;
    logic               take;
    logic               accept;
    logic               drop;
    logic [ACC_W-1:0]   acc_next;
    logic [FILL_W-1:0]  fill_next;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state != IDLE);
    assign mode_ok       = ({{(32-MODE_W){1'b0}}, mode} < 32'(NSRC));

    // Pick the selected source's strobe and data without a variable-width index
    always_comb begin
        cand_valid = 1'b0;
        cand_data  = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == MODE_W'(k)) begin
                cand_valid = bus.in_valid[k];
                cand_data  = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Emit/accept decisions; bits above fill are always zero, so acc[7:0]
    // is already the zero-padded byte in the partial drain case
    always_comb begin
        loadable  = !out_valid_q || bus.out_ready;
        emit_full = loadable && (state != IDLE) && (fill >= FILL_W'(8));
        emit_part = loadable && (state == DRAIN) && (fill != '0) && (fill < FILL_W'(8));
        emit      = emit_full || emit_part;
        fill_base = emit_part ? '0 : (emit_full ? fill - FILL_W'(8) : fill);
        acc_base  = emit_part ? '0 : (emit_full ? (acc >> 8) : acc);
        fits      = (int'(fill_base) + WIDTH) <= ACC_W;
        take      = (state == RUN) && cand_valid;
        accept    = take && fits;
        drop      = take && !fits;
        acc_next  = accept ? (acc_base | (ACC_W'(cand_data) << fill_base)) : acc_base;
        fill_next = accept ? (fill_base + FILL_W'(WIDTH)) : fill_base;
    end

    // Accumulator and output byte register with valid/ready hold
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc         <= '0;
            fill        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
            if (emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= acc[7:0];
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Stream control: latch the source on start, drain on stop or source change
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && mode_ok) begin
                        state <= RUN;
                        sel   <= mode;
                    end
                end
                RUN: begin
                    if (!enable || (mode != sel)) state <= DRAIN;
                end
                DRAIN: begin
                    if (fill == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr)                   drop_count <= CNT_W'(1);
            else if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_sample_mux_packer.sv
// Directed self-checking bench for sample_mux_packer (WIDTH=12, NSRC=2).
module tb_sample_mux_packer;
    logic        clk;
    logic        nreset;
    logic        enable;
    logic [1:0]  mode;
    logic        clr;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    logic [7:0] got[$];
    logic [7:0] act;

    sample_mux_packer_if #(.WIDTH(12), .NSRC(2)) bus ();

    sample_mux_packer #(.WIDTH(12), .NSRC(2), .MODE_W(2), .CNT_W(16)) dut (
        .clk(clk), .nreset(nreset), .enable(enable), .mode(mode), .clr(clr),
        .bus(bus), .busy(busy), .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that is handed over at the coming rising edge
    always @(negedge clk) begin
        if (nreset && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive_sample(input int src, input logic [11:0] d);
        bus.in_valid = '0;
        bus.in_valid[src] = 1'b1;
        bus.in_data[src*12 +: 12] = d;
    endtask

    task automatic test_reset();
        nreset = 1'b0; enable = 1'b0; mode = 2'd0; clr = 1'b0;
        bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %h want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data got %h want 00", bus.out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %h want 0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got %h want 0", overflow); end
        checks++; if (drop_count !== 16'h0) begin failures++; $display("[TB] FAIL reset_drop_count got %h want 0", drop_count); end
        steps(2);
        nreset = 1'b1;
        step();
    endtask

    task automatic test_basic_pack();
        logic [7:0] exp_b [3];
        exp_b = '{8'hBC, 8'h3A, 8'h12};
        got.delete();
        enable = 1'b1; mode = 2'd0;
        step();
        drive_sample(0, 12'hABC);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid got %h want 0", bus.out_valid); end
        drive_sample(0, 12'h123);
        step();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_latency_valid got %h want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hBC) begin failures++; $display("[TB] FAIL basic_first_byte got %h want bc", bus.out_data); end
        bus.in_valid = '0;
        steps(5);
        checks++; if (got.size() != 3) begin failures++; $display("[TB] FAIL basic_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (act !== exp_b[i]) begin failures++; $display("[TB] FAIL basic_byte%0d got %h want %h", i, act, exp_b[i]); end
        end
        checks++; if (dut.fill !== 5'd0) begin failures++; $display("[TB] FAIL basic_fill got %0d want 0", dut.fill); end
        checks++; if (drop_count !== 16'h0) begin failures++; $display("[TB] FAIL basic_drops got %h want 0", drop_count); end
        enable = 1'b0;
        steps(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle got %h want 0", busy); end
    endtask

    task automatic test_flush_on_disable();
        got.delete();
        enable = 1'b1; mode = 2'd0;
        step();
        drive_sample(0, 12'hABC);
        step();
        bus.in_valid = '0; enable = 1'b0;
        steps(2);
        checks++; if (bus.out_data !== 8'h0A) begin failures++; $display("[TB] FAIL flush_pad_byte got %h want 0a", bus.out_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy_at_pad got %h want 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy_after got %h want 0", busy); end
        steps(2);
        checks++; if (got.size() != 2) begin failures++; $display("[TB] FAIL flush_count got %0d want 2", got.size()); end
        act = (got.size() > 0) ? got[0] : 8'hxx;
        checks++; if (act !== 8'hBC) begin failures++; $display("[TB] FAIL flush_byte0 got %h want bc", act); end
        act = (got.size() > 1) ? got[1] : 8'hxx;
        checks++; if (act !== 8'h0A) begin failures++; $display("[TB] FAIL flush_byte1 got %h want 0a", act); end
    endtask

    task automatic test_backpressure();
        logic [11:0] s [5];
        logic [7:0]  exp_b [5];
        s = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'hFED};
        exp_b = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h09};
        got.delete();
        bus.out_ready = 1'b0; enable = 1'b1; mode = 2'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            drive_sample(0, s[i]);
            step();
        end
        bus.in_valid = '0;
        step();
        checks++; if (drop_count !== 16'd2) begin failures++; $display("[TB] FAIL bp_drop_count got %0d want 2", drop_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL bp_overflow got %h want 1", overflow); end
        checks++; if (bus.out_data !== 8'h21) begin failures++; $display("[TB] FAIL bp_held_data got %h want 21", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_held_valid got %h want 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        steps(6);
        checks++; if (got.size() != 4) begin failures++; $display("[TB] FAIL bp_count got %0d want 4", got.size()); end
        checks++; if (dut.fill !== 5'd4) begin failures++; $display("[TB] FAIL bp_residue got %0d want 4", dut.fill); end
        enable = 1'b0;
        steps(4);
        for (int i = 0; i < 5; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (act !== exp_b[i]) begin failures++; $display("[TB] FAIL bp_byte%0d got %h want %h", i, act, exp_b[i]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle got %h want 0", busy); end
    endtask

    task automatic test_mode_switch();
        logic [7:0] exp_b [5];
        exp_b = '{8'hA5, 8'h05, 8'hC3, 8'h10, 8'h7E};
        got.delete();
        enable = 1'b1; mode = 2'd0;
        step();
        drive_sample(0, 12'h5A5);
        step();
        bus.in_valid = '0; mode = 2'd1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_sample(0, 12'hEEE);
            step();
        end
        bus.in_valid = 2'b11; bus.in_data = {12'h0C3, 12'hEEE};
        step();
        bus.in_valid = 2'b10; bus.in_data = {12'h7E1, 12'hEEE};
        step();
        drive_sample(0, 12'hEEE);
        step();
        bus.in_valid = '0;
        steps(4);
        checks++; if (got.size() != 5) begin failures++; $display("[TB] FAIL ms_count got %0d want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (act !== exp_b[i]) begin failures++; $display("[TB] FAIL ms_byte%0d got %h want %h", i, act, exp_b[i]); end
        end
        enable = 1'b0; mode = 2'd0;
        steps(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ms_idle got %h want 0", busy); end
    endtask

    task automatic test_no_source_and_clr();
        got.delete();
        enable = 1'b1; mode = 2'd3;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i % 2 == 0) ? 2'b11 : 2'b01;
            bus.in_data = {12'h0F0 + 12'(i), 12'h111 * 12'(i)};
            step();
            checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL nosrc_busy%0d got %h want 0", i, busy); end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL nosrc_valid%0d got %h want 0", i, bus.out_valid); end
        end
        bus.in_valid = '0;
        step();
        checks++; if (got.size() != 0) begin failures++; $display("[TB] FAIL nosrc_bytes got %0d want 0", got.size()); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL clr_pre_overflow got %h want 1", overflow); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL clr_overflow got %h want 0", overflow); end
        checks++; if (drop_count !== 16'h0) begin failures++; $display("[TB] FAIL clr_drop_count got %h want 0", drop_count); end
        bus.out_ready = 1'b0; mode = 2'd0;
        step();
        drive_sample(0, 12'h111); step();
        drive_sample(0, 12'h222); step();
        drive_sample(0, 12'h333); step();
        drive_sample(0, 12'h444); clr = 1'b1; step();
        bus.in_valid = '0; clr = 1'b0;
        step();
        checks++; if (drop_count !== 16'd1) begin failures++; $display("[TB] FAIL clr_drop_wins_count got %0d want 1", drop_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL clr_drop_wins_ovf got %h want 1", overflow); end
        bus.out_ready = 1'b1; enable = 1'b0;
        steps(8);
        got.delete();
    endtask

    task automatic test_async_reset();
        got.delete();
        bus.out_ready = 1'b1; enable = 1'b1; mode = 2'd0;
        step();
        drive_sample(0, 12'hABC); step();
        drive_sample(0, 12'h123); step();
        drive_sample(0, 12'h456); step();
        bus.in_valid = '0; bus.out_ready = 1'b0;
        step();
        checks++; if (dut.fill !== 5'd20) begin failures++; $display("[TB] FAIL rst_pre_fill got %0d want 20", dut.fill); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_valid got %h want 1", bus.out_valid); end
        #2;
        nreset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_valid got %h want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_async_data got %h want 00", bus.out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_busy got %h want 0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_overflow got %h want 0", overflow); end
        checks++; if (drop_count !== 16'h0) begin failures++; $display("[TB] FAIL rst_async_drops got %h want 0", drop_count); end
        step();
        nreset = 1'b1;
        got.delete();
        bus.out_ready = 1'b1;
        step();
        drive_sample(0, 12'h3C7);
        step();
        bus.in_valid = '0; enable = 1'b0;
        steps(5);
        checks++; if (got.size() != 2) begin failures++; $display("[TB] FAIL rst_after_count got %0d want 2", got.size()); end
        act = (got.size() > 0) ? got[0] : 8'hxx;
        checks++; if (act !== 8'hC7) begin failures++; $display("[TB] FAIL rst_after_byte0 got %h want c7", act); end
        act = (got.size() > 1) ? got[1] : 8'hxx;
        checks++; if (act !== 8'h03) begin failures++; $display("[TB] FAIL rst_after_byte1 got %h want 03", act); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic_pack();
        test_flush_on_disable();
        test_backpressure();
        test_mode_switch();
        test_no_source_and_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sample_mux_packer.md
Name: sample_mux_packer

Overview:
- Parametrised successor to the fixed ADC/sawtooth source select and 12-to-8 packer in the sample path.
- Selects one of NSRC sample sources by mode and packs WIDTH-bit samples into an LSB-first byte stream.
- Adds downstream backpressure, overflow accounting, and a clean drain with zero-padded flush on mode change or disable.
- Sits between the sample sources (ADC reader, pattern generators) and the packeter.

Parameters:
- WIDTH, 12, sample width in bits; legal range 4..16.
- NSRC, 2, number of sample sources; legal range 1..2**MODE_W.
- MODE_W, 2, width of the mode port.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  stream enable, from the registers block.
- mode  in  MODE_W  source select; values >= NSRC mean "no source".
- clr  in  1  single-cycle pulse; clears overflow and drop_count.
- in_valid  in  NSRC  per-source sample strobe.
- in_data  in  NSRC*WIDTH  source k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  output byte valid.
- out_data  out  8  output byte.
- out_ready  in  1  downstream accepts the byte.
- busy  out  1  high while in RUN or DRAIN.
- overflow  out  1  sticky; set when a sample is dropped.
- drop_count  out  CNT_W  saturating count of dropped samples.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - nreset low forces, asynchronously: state=IDLE, accumulator fill=0, out_valid=0, out_data=0, busy=0, overflow=0, drop_count=0.
  - Reset mid-stream discards the accumulator contents and any pending output byte.
- Accumulator
  - ACC_W = 2*WIDTH+7 bits; fill counter holds 0..ACC_W.
  - An accepted sample is appended above the existing residue: acc |= sample << fill.
  - Bytes are taken from acc[7:0]; acc then shifts right by 8.
- Output register handshake
  - Transfer occurs when out_valid && out_ready.
  - The register loads when (!out_valid || out_ready) and a byte is available.
  - out_data is held stable while out_valid && !out_ready.
  - out_valid drops only after a transfer with no new byte to load.
- emit (one-cycle event)
  - Condition: register loadable && (fill>=8, or state==DRAIN && 0<fill<8).
  - The partial case loads the residue zero-extended into the high bits; fill goes to 0.
  - At most one byte per cycle.
- FSM
  - IDLE: no accept, no emit. Goes to RUN when enable=1 && mode<NSRC; the cycle of transition latches sel=mode.
  - RUN: in_valid[sel] && in_data[sel] are the candidate sample; other sources are ignored. Goes to DRAIN when enable=0 or mode!=sel (evaluated every cycle). A sample presented in the transition cycle is still processed.
  - DRAIN: no accept. Emits full bytes, then one zero-padded partial byte if a residue exists. Goes to IDLE when fill==0. A pending out register does not block the IDLE transition.
  - busy = (state != IDLE).
  - With mode >= NSRC the block stays in IDLE; all inputs are ignored and no output is produced.
- Accept rule (RUN only)
  - Accept if (fill - (emit?8:0) + WIDTH) <= ACC_W.
  - Otherwise the sample is dropped: overflow<=1, and drop_count increments, saturating at all-ones.
  - fill_next = fill - 8*emit + WIDTH*accept; emit and accept may occur in the same cycle.
- Latency
  - A sample accepted in cycle N with fill+WIDTH>=8 and a free out register gives out_valid=1 in cycle N+1 with its first byte.
  - Sustained throughput is 1 byte/cycle; sample rate must satisfy WIDTH*rate <= 8 bits/cycle to avoid drops.
- clr
  - Clears overflow and drop_count.
  - If a drop occurs in the same cycle as clr, the drop wins: overflow=1, drop_count=1.
- Ordering
  - The byte stream is a strict LSB-first concatenation of the accepted samples.
  - No byte is ever duplicated or reordered across backpressure.

Test Plan:
- WIDTH=12, out_ready=1, RUN on source 0; samples 0xABC then 0x123 → out_data sequence 0xBC, 0x3A, 0x12; fill returns to 0; drop_count=0.
- Single sample 0xABC, then enable=0 → bytes 0xBC, 0x0A (zero-padded); busy falls after the padded byte loads; state=IDLE.
- out_ready=0, five back-to-back samples S0..S4 → S0..S2 accepted, S3 and S4 dropped; drop_count=2, overflow=1; out_data held at S0[7:0]. Then out_ready=1 → four bytes matching the LSB-first concatenation of S0..S2; 4 residue bits stay until flush.
- Stream 0x5A5 on source 0, switch mode to 1 mid-stream → drain emits 0xA5, then 0x05 padded. Next cycle IDLE→RUN with sel=1; only source-1 samples appear afterwards; source-0 strobes are ignored.
- NSRC=2, mode=3, enable=1, in_valid toggling → busy=0, out_valid=0 throughout. Then clr with overflow=1 → overflow=0, drop_count=0. clr coincident with a drop → drop_count=1.
- nreset asserted while out_valid=1 with 20 bits in the accumulator → all outputs 0 immediately (asynchronously). After release, the first new sample's bytes contain no old residue.
